// File: rtl/riscv_cache_setup_q_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_cache_setup_q_if : request/staged-request bus of the setup queue   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface riscv_cache_setup_q_if #(
  parameter int XLEN       = 32,
  parameter int SIZE       = 64,
  parameter int BLOCK_SIZE = XLEN,
  parameter int WAYS       = 2,
  parameter int DEPTH      = 2
);
  localparam int SETS          = (SIZE * 1024 * 8) / BLOCK_SIZE / WAYS;
  localparam int BLK_OFFS_BITS = $clog2(BLOCK_SIZE / 8);
  localparam int IDX_BITS      = $clog2(SETS);
  localparam int TAG_BITS      = XLEN - IDX_BITS - BLK_OFFS_BITS;
  localparam int CNT_BITS      = $clog2(DEPTH + 1);

  // size: 0=BYTE 1=HWORD 2=WORD 3=DWORD; prot is an opaque 3-bit field
  logic                flush_i;
  logic                req_i;
  logic                req_rdy_o;
  logic [XLEN-1:0]     adr_i;
  logic [2:0]          size_i;
  logic                lock_i;
  logic [2:0]          prot_i;
  logic                we_i;
  logic [XLEN-1:0]     d_i;
  logic                is_cacheable_i;
  logic                is_misaligned_i;
  logic                req_o;
  logic                req_rdy_i;
  logic [XLEN-1:0]     adr_o;
  logic [2:0]          size_o;
  logic                lock_o;
  logic [2:0]          prot_o;
  logic                is_cacheable_o;
  logic                is_misaligned_o;
  logic [IDX_BITS-1:0] tag_idx_o;
  logic [IDX_BITS-1:0] dat_idx_o;
  logic [TAG_BITS-1:0] core_tag_o;
  logic                writebuffer_we_o;
  logic [IDX_BITS-1:0] writebuffer_idx_o;
  logic [XLEN-1:0]     writebuffer_data_o;
  logic [XLEN/8-1:0]   writebuffer_be_o;
  logic [CNT_BITS-1:0] level_o;

  modport slave (
    input  flush_i, req_i, adr_i, size_i, lock_i, prot_i, we_i, d_i,
           is_cacheable_i, is_misaligned_i, req_rdy_i,
    output req_rdy_o, req_o, adr_o, size_o, lock_o, prot_o, is_cacheable_o,
           is_misaligned_o, tag_idx_o, dat_idx_o, core_tag_o, writebuffer_we_o,
           writebuffer_idx_o, writebuffer_data_o, writebuffer_be_o, level_o
  );

  modport master (
    output flush_i, req_i, adr_i, size_i, lock_i, prot_i, we_i, d_i,
           is_cacheable_i, is_misaligned_i, req_rdy_i,
    input  req_rdy_o, req_o, adr_o, size_o, lock_o, prot_o, is_cacheable_o,
           is_misaligned_o, tag_idx_o, dat_idx_o, core_tag_o, writebuffer_we_o,
           writebuffer_idx_o, writebuffer_data_o, writebuffer_be_o, level_o
  );
endinterface
`default_nettype wire

// File: rtl/riscv_cache_setup_q.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_cache_setup_q : queued address-setup stage ahead of cache lookup   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module riscv_cache_setup_q #(
  parameter int XLEN       = 32,
  parameter int SIZE       = 64,
  parameter int BLOCK_SIZE = XLEN,
  parameter int WAYS       = 2,
  parameter int DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  riscv_cache_setup_q_if.slave  bus
);
  localparam int SETS          = (SIZE * 1024 * 8) / BLOCK_SIZE / WAYS;
  localparam int BLK_OFFS_BITS = $clog2(BLOCK_SIZE / 8);
  localparam int IDX_BITS      = $clog2(SETS);
  localparam int TAG_BITS      = XLEN - IDX_BITS - BLK_OFFS_BITS;
  localparam int CNT_BITS      = $clog2(DEPTH + 1);
  localparam int PTR_BITS      = $clog2(DEPTH);
  localparam int BE_BITS       = XLEN / 8;
  localparam int BE_OFFS       = $clog2(BE_BITS);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("riscv_cache_setup_q: DEPTH must be a power of 2 and >= 2");
  end
  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $error("riscv_cache_setup_q: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0] adr;
    logic [2:0]      size;
    logic            lock;
    logic [2:0]      prot;
    logic            we;
    logic [XLEN-1:0] d;
    logic            cacheable;
    logic            misaligned;
  } entry_t;

  entry_t               mem [DEPTH];
  entry_t               incoming, head, src;
  logic [PTR_BITS-1:0]  rd_ptr, wr_ptr;
  logic [CNT_BITS-1:0]  level;
  logic                 empty, push, adv, pop, wr_fifo, load;
  logic [IDX_BITS-1:0]  sel_idx;

  function automatic logic [BE_BITS-1:0] be_of(input logic [2:0] sz,
                                                input logic [BE_OFFS-1:0] offs);
    logic [7:0] m;
    case (sz)
      3'd0:    m = 8'h01;
      3'd1:    m = 8'h03;
      3'd2:    m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m[BE_BITS-1:0] << offs;
  endfunction

  assign incoming = '{adr: bus.adr_i, size: bus.size_i, lock: bus.lock_i,
                      prot: bus.prot_i, we: bus.we_i, d: bus.d_i,
                      cacheable: bus.is_cacheable_i, misaligned: bus.is_misaligned_i};
  assign head     = mem[rd_ptr];

  // Ready depends only on the registered count, never on req_rdy_i.
  assign empty         = (level == '0);
  assign bus.req_rdy_o = (level != CNT_BITS'(DEPTH));
  assign push          = bus.req_i & bus.req_rdy_o & ~bus.flush_i;
  assign adv           = ~bus.req_o | bus.req_rdy_i;
  assign pop           = adv & ~empty;
  assign wr_fifo       = push & (~empty | ~adv);
  assign load          = adv & (pop | push);
  assign src           = pop ? head : incoming;
  assign bus.level_o   = level;

  // Index presented one cycle ahead so the memories capture the next occupant.
  always_comb begin
    sel_idx = bus.writebuffer_idx_o;
    if (bus.flush_i)
      sel_idx = bus.adr_i[BLK_OFFS_BITS +: IDX_BITS];
    else if (adv && !empty)
      sel_idx = head.adr[BLK_OFFS_BITS +: IDX_BITS];
    else if (adv)
      sel_idx = bus.adr_i[BLK_OFFS_BITS +: IDX_BITS];
  end

  assign bus.tag_idx_o = sel_idx;
  assign bus.dat_idx_o = sel_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      bus.req_o            <= 1'b0;
      bus.writebuffer_we_o <= 1'b0;
      level                <= '0;
      rd_ptr               <= '0;
      wr_ptr               <= '0;
    end else begin
      if (adv) begin
        bus.req_o            <= pop | push;
        bus.writebuffer_we_o <= (pop | push) & src.we;
      end
      level <= level + CNT_BITS'(wr_fifo) - CNT_BITS'(pop);
      if (wr_fifo) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_BITS'(1);
    end
  end

  // Payload storage is deliberately unreset.
  always_ff @(posedge clk_i) begin
    if (wr_fifo) mem[wr_ptr] <= incoming;
    if (load) begin
      bus.adr_o              <= src.adr;
      bus.size_o             <= src.size;
      bus.lock_o             <= src.lock;
      bus.prot_o             <= src.prot;
      bus.is_cacheable_o     <= src.cacheable;
      bus.is_misaligned_o    <= src.misaligned;
      bus.core_tag_o         <= src.adr[XLEN-1 -: TAG_BITS];
      bus.writebuffer_idx_o  <= src.adr[BLK_OFFS_BITS +: IDX_BITS];
      bus.writebuffer_data_o <= src.d;
      bus.writebuffer_be_o   <= be_of(src.size, src.adr[BE_OFFS-1:0]);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_riscv_cache_setup_q.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_riscv_cache_setup_q : directed self-checking bench for setup queue    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_riscv_cache_setup_q;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk_i = ~clk_i;

  riscv_cache_setup_q_if #(.XLEN(32), .SIZE(64), .BLOCK_SIZE(32), .WAYS(2), .DEPTH(2)) b32 ();
  riscv_cache_setup_q_if #(.XLEN(64), .SIZE(64), .BLOCK_SIZE(64), .WAYS(2), .DEPTH(2)) b64 ();

  riscv_cache_setup_q #(.XLEN(32), .SIZE(64), .BLOCK_SIZE(32), .WAYS(2), .DEPTH(2)) u_dut32 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(b32));
  riscv_cache_setup_q #(.XLEN(64), .SIZE(64), .BLOCK_SIZE(64), .WAYS(2), .DEPTH(2)) u_dut64 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(b64));

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    b32.flush_i = 0; b32.req_i = 0; b32.adr_i = '0; b32.size_i = 3'd2; b32.lock_i = 0;
    b32.prot_i = '0; b32.we_i = 0; b32.d_i = '0; b32.is_cacheable_i = 1;
    b32.is_misaligned_i = 0; b32.req_rdy_i = 1;
    b64.flush_i = 0; b64.req_i = 0; b64.adr_i = '0; b64.size_i = 3'd2; b64.lock_i = 0;
    b64.prot_i = '0; b64.we_i = 0; b64.d_i = '0; b64.is_cacheable_i = 1;
    b64.is_misaligned_i = 0; b64.req_rdy_i = 1;
    rst_i = 1;
    step(); step();
    rst_i = 0;
    checks++; if (b32.req_o !== 1'b0) begin errors++; $display("FAIL reset_req_o: got %0h want 0", b32.req_o); end
    checks++; if (b32.writebuffer_we_o !== 1'b0) begin errors++; $display("FAIL reset_wb_we: got %0h want 0", b32.writebuffer_we_o); end
    checks++; if (b32.level_o !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", b32.level_o); end
    checks++; if (b32.req_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %0h want 1", b32.req_rdy_o); end
    checks++; if (b64.req_o !== 1'b0) begin errors++; $display("FAIL reset64_req_o: got %0h want 0", b64.req_o); end
  endtask

  task automatic test_bypass();
    b32.req_i = 1; b32.adr_i = 32'h0000_1040; b32.req_rdy_i = 1;
    #1;
    checks++; if (b32.tag_idx_o !== 13'h410) begin errors++; $display("FAIL bypass_tag_idx: got %0h want 410", b32.tag_idx_o); end
    checks++; if (b32.dat_idx_o !== 13'h410) begin errors++; $display("FAIL bypass_dat_idx: got %0h want 410", b32.dat_idx_o); end
    step();
    b32.req_i = 0;
    checks++; if (b32.req_o !== 1'b1) begin errors++; $display("FAIL bypass_req_o: got %0h want 1", b32.req_o); end
    checks++; if (b32.adr_o !== 32'h1040) begin errors++; $display("FAIL bypass_adr: got %0h want 1040", b32.adr_o); end
    checks++; if (b32.level_o !== 2'd0) begin errors++; $display("FAIL bypass_level: got %0d want 0", b32.level_o); end
    checks++; if (b32.writebuffer_idx_o !== 13'h410) begin errors++; $display("FAIL bypass_wb_idx: got %0h want 410", b32.writebuffer_idx_o); end
    step();
    checks++; if (b32.req_o !== 1'b0) begin errors++; $display("FAIL bypass_drain: got %0h want 0", b32.req_o); end
  endtask

  task automatic test_queue();
    b32.req_rdy_i = 0; b32.req_i = 1; b32.adr_i = 32'h0000_2000;
    step();
    b32.adr_i = 32'h0000_3004;
    step();
    b32.adr_i = 32'h0000_4008;
    step();
    b32.req_i = 0;
    #1;
    checks++; if (b32.level_o !== 2'd2) begin errors++; $display("FAIL queue_level_full: got %0d want 2", b32.level_o); end
    checks++; if (b32.req_rdy_o !== 1'b0) begin errors++; $display("FAIL queue_rdy_full: got %0h want 0", b32.req_rdy_o); end
    checks++; if (b32.tag_idx_o !== 13'h800) begin errors++; $display("FAIL queue_idx_hold: got %0h want 800", b32.tag_idx_o); end
    checks++; if (b32.adr_o !== 32'h2000) begin errors++; $display("FAIL queue_adr_x: got %0h want 2000", b32.adr_o); end
    b32.req_rdy_i = 1;
    #1;
    checks++; if (b32.tag_idx_o !== 13'h0c01) begin errors++; $display("FAIL queue_idx_a: got %0h want c01", b32.tag_idx_o); end
    step();
    checks++; if (b32.adr_o !== 32'h3004) begin errors++; $display("FAIL queue_adr_a: got %0h want 3004", b32.adr_o); end
    checks++; if (b32.level_o !== 2'd1) begin errors++; $display("FAIL queue_level_a: got %0d want 1", b32.level_o); end
    checks++; if (b32.tag_idx_o !== 13'h1002) begin errors++; $display("FAIL queue_idx_b: got %0h want 1002", b32.tag_idx_o); end
    step();
    checks++; if (b32.adr_o !== 32'h4008 || b32.req_o !== 1'b1) begin errors++; $display("FAIL queue_adr_b: got %0h/%0h want 4008/1", b32.adr_o, b32.req_o); end
    checks++; if (b32.level_o !== 2'd0) begin errors++; $display("FAIL queue_level_b: got %0d want 0", b32.level_o); end
    step();
    checks++; if (b32.req_o !== 1'b0) begin errors++; $display("FAIL queue_drain: got %0h want 0", b32.req_o); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pat;
    int issued, ndel, mcnt;
    bit mv, push, adv, rdy;
    pat = 16'b1111_1011_1011_0100;
    issued = 0; ndel = 0; mcnt = 0; mv = 0;
    for (int cyc = 0; cyc < 40 && ndel < 8; cyc++) begin
      rdy = pat[cyc % 16];
      b32.req_i = (issued < 8);
      b32.adr_i = 32'h0000_5000 + 32'(issued * 64);
      b32.req_rdy_i = rdy;
      #1;
      push = (issued < 8) && (mcnt < 2);
      checks++; if (b32.req_rdy_o !== (mcnt < 2)) begin errors++; $display("FAIL b2b_rdy cyc%0d: got %0h want %0h", cyc, b32.req_rdy_o, (mcnt < 2)); end
      if (mv && rdy) begin
        checks++;
        if (b32.adr_o !== 32'h0000_5000 + 32'(ndel * 64)) begin
          errors++; $display("FAIL b2b_order #%0d: got %0h want %0h", ndel, b32.adr_o, 32'h5000 + 32'(ndel * 64));
        end
        ndel++;
      end
      adv = !mv || rdy;
      if (adv) begin
        if (mcnt > 0) begin mv = 1; mcnt = mcnt - 1 + int'(push); end
        else mv = push;
      end else begin
        mcnt = mcnt + int'(push);
      end
      if (push) issued++;
      step();
      checks++; if (b32.req_o !== mv) begin errors++; $display("FAIL b2b_req_o cyc%0d: got %0h want %0h", cyc, b32.req_o, mv); end
      checks++; if (b32.level_o !== 2'(mcnt)) begin errors++; $display("FAIL b2b_level cyc%0d: got %0d want %0d", cyc, b32.level_o, mcnt); end
    end
    checks++; if (ndel != 8) begin errors++; $display("FAIL b2b_delivered: got %0d want 8", ndel); end
    b32.req_i = 0; b32.req_rdy_i = 1;
    step(); step(); step();
  endtask

  task automatic test_flush();
    b32.req_rdy_i = 0; b32.we_i = 1; b32.size_i = 3'd2; b32.req_i = 1;
    b32.adr_i = 32'h0000_6000; step();
    b32.adr_i = 32'h0000_6040; step();
    b32.adr_i = 32'h0000_6080; step();
    checks++; if (b32.level_o !== 2'd2 || b32.writebuffer_we_o !== 1'b1) begin errors++; $display("FAIL flush_setup: got lvl %0d we %0h want 2/1", b32.level_o, b32.writebuffer_we_o); end
    b32.flush_i = 1; b32.adr_i = 32'h0000_60c0;
    #1;
    checks++; if (b32.tag_idx_o !== 13'h1830) begin errors++; $display("FAIL flush_idx: got %0h want 1830", b32.tag_idx_o); end
    step();
    b32.flush_i = 0; b32.req_i = 0; b32.we_i = 0;
    checks++; if (b32.req_o !== 1'b0) begin errors++; $display("FAIL flush_req_o: got %0h want 0", b32.req_o); end
    checks++; if (b32.level_o !== 2'd0) begin errors++; $display("FAIL flush_level: got %0d want 0", b32.level_o); end
    checks++; if (b32.writebuffer_we_o !== 1'b0) begin errors++; $display("FAIL flush_wb_we: got %0h want 0", b32.writebuffer_we_o); end
    checks++; if (b32.req_rdy_o !== 1'b1) begin errors++; $display("FAIL flush_rdy: got %0h want 1", b32.req_rdy_o); end
    b32.req_rdy_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (b32.req_o !== 1'b0) begin errors++; $display("FAIL flush_ghost %0d: got %0h want 0", i, b32.req_o); end
    end
  endtask

  task automatic test_byte_enable();
    b32.req_rdy_i = 1; b32.req_i = 1; b32.we_i = 1; b32.d_i = 32'hdead_beef;
    b32.size_i = 3'd0; b32.adr_i = 32'h0000_7003;
    b64.req_rdy_i = 1; b64.req_i = 1; b64.we_i = 1; b64.size_i = 3'd1;
    b64.adr_i = 64'h0000_0000_0000_8006;
    step();
    checks++; if (b32.writebuffer_be_o !== 4'h8) begin errors++; $display("FAIL be32_byte: got %0h want 8", b32.writebuffer_be_o); end
    checks++; if (b32.writebuffer_we_o !== 1'b1) begin errors++; $display("FAIL be32_we: got %0h want 1", b32.writebuffer_we_o); end
    checks++; if (b32.writebuffer_data_o !== 32'hdead_beef) begin errors++; $display("FAIL be32_data: got %0h want deadbeef", b32.writebuffer_data_o); end
    checks++; if (b64.writebuffer_be_o !== 8'hc0) begin errors++; $display("FAIL be64_hword: got %0h want c0", b64.writebuffer_be_o); end
    b32.size_i = 3'd3; b32.adr_i = 32'h0000_7010;
    b64.size_i = 3'd2; b64.adr_i = 64'h0000_0000_0000_8004;
    step();
    checks++; if (b32.writebuffer_be_o !== 4'hf) begin errors++; $display("FAIL be32_dword: got %0h want f", b32.writebuffer_be_o); end
    checks++; if (b64.writebuffer_be_o !== 8'hf0) begin errors++; $display("FAIL be64_word: got %0h want f0", b64.writebuffer_be_o); end
    b32.size_i = 3'd1; b32.adr_i = 32'h0000_7002;
    b64.req_i = 0;
    step();
    checks++; if (b32.writebuffer_be_o !== 4'hc) begin errors++; $display("FAIL be32_hword: got %0h want c", b32.writebuffer_be_o); end
    b32.req_i = 0; b32.we_i = 0;
    step();
    checks++; if (b32.req_o !== 1'b0 || b32.writebuffer_we_o !== 1'b0) begin errors++; $display("FAIL be_drain: got %0h/%0h want 0/0", b32.req_o, b32.writebuffer_we_o); end
  endtask

  task automatic test_reset_mid();
    b32.req_rdy_i = 0; b32.req_i = 1; b32.we_i = 1;
    b32.adr_i = 32'h0000_9000; step();
    b32.adr_i = 32'h0000_9040; step();
    b32.req_i = 0; b32.we_i = 0;
    checks++; if (b32.level_o !== 2'd1) begin errors++; $display("FAIL rstmid_setup: got %0d want 1", b32.level_o); end
    rst_i = 1;
    step();
    rst_i = 0;
    checks++; if (b32.req_o !== 1'b0) begin errors++; $display("FAIL rstmid_req_o: got %0h want 0", b32.req_o); end
    checks++; if (b32.level_o !== 2'd0) begin errors++; $display("FAIL rstmid_level: got %0d want 0", b32.level_o); end
    checks++; if (b32.writebuffer_we_o !== 1'b0) begin errors++; $display("FAIL rstmid_wb_we: got %0h want 0", b32.writebuffer_we_o); end
    checks++; if (b32.req_rdy_o !== 1'b1) begin errors++; $display("FAIL rstmid_rdy: got %0h want 1", b32.req_rdy_o); end
    b32.req_rdy_i = 1;
    step();
    checks++; if (b32.req_o !== 1'b0) begin errors++; $display("FAIL rstmid_residue: got %0h want 0", b32.req_o); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_queue();
    test_back_to_back();
    test_flush();
    test_byte_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
